uart_rx_ctrl: RTL and testbench

Control and buffering companion for the uart_rx receiver. It owns the receiver's runtime configuration (prescale, parity_en, parity_type) and applies software writes only while the serial line is idle, so a frame is never corrupted mid-reception. It captures every received byte into a small first-word-fall-through FIFO with a valid/ready read port and a sticky overflow flag for the host side.

---
 rtl/uart_rx_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx companion: idle-gated runtime config, FWFT receive FIFO, overflow flag.
// Define UART_RX_CTRL_TIMEOUT_EN to build the receive-timeout counter.
module uart_rx_ctrl #(
    parameter int DWIDTH       = 8,
    parameter int PWIDTH       = 6,
    parameter int AWIDTH       = 3,
    parameter int IDLE_BITS    = 11,
    parameter int PRESCALE_RST = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_data,
    input  logic [DWIDTH-1:0] rx_p_data,
    input  logic              rx_data_valid,
    output logic [PWIDTH-1:0] prescale,
    output logic              parity_en,
    output logic              parity_type,
    input  logic              cfg_wr,
    input  logic [PWIDTH-1:0] cfg_prescale,
    input  logic              cfg_parity_en,
    input  logic              cfg_parity_type,
    output logic              cfg_pending,
    output logic              line_idle,
    output logic [DWIDTH-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [AWIDTH:0]   fifo_level,
    output logic              overflow,
    input  logic              ovf_clr,
    output logic              rx_timeout
);

    localparam int DEPTH = 1 << AWIDTH;
    localparam int CMAX  = IDLE_BITS * ((1 << PWIDTH) - 1);
    localparam int CW    = $clog2(CMAX + 1);
    localparam int TW    = CW + 2;

    typedef enum logic {
        CFG_IDLE,
        CFG_PEND
    } cfg_state_t;

    cfg_state_t        state;
    logic [PWIDTH-1:0] sh_prescale;
    logic              sh_parity_en;
    logic              sh_parity_type;
    logic              cfg_acc;

    logic [CW-1:0] idle_cnt;
    logic [CW-1:0] idle_nxt;
    logic [CW-1:0] idle_thr;

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AWIDTH:0]   wr_ptr;
    logic [AWIDTH:0]   rd_ptr;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              drop;

    assign idle_thr = CW'(IDLE_BITS) * CW'(prescale);

    always_comb begin
        idle_nxt = idle_cnt;
        if (!s_data)
            idle_nxt = '0;
        else if (idle_cnt < idle_thr)
            idle_nxt = idle_cnt + CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt  <= '0;
            line_idle <= 1'b0;
        end else begin
            idle_cnt  <= idle_nxt;
            line_idle <= (idle_nxt >= idle_thr);
        end
    end

    // A zero prescale would stall uart_rx, so such writes are dropped.
    assign cfg_acc = cfg_wr && (cfg_prescale != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= CFG_IDLE;
            cfg_pending    <= 1'b0;
            sh_prescale    <= PWIDTH'(PRESCALE_RST);
            sh_parity_en   <= 1'b1;
            sh_parity_type <= 1'b0;
            prescale       <= PWIDTH'(PRESCALE_RST);
            parity_en      <= 1'b1;
            parity_type    <= 1'b0;
        end else begin
            unique case (state)
                CFG_IDLE: begin
                    if (cfg_acc) begin
                        sh_prescale    <= cfg_prescale;
                        sh_parity_en   <= cfg_parity_en;
                        sh_parity_type <= cfg_parity_type;
                        state          <= CFG_PEND;
                        cfg_pending    <= 1'b1;
                    end
                end
                CFG_PEND: begin
                    if (cfg_acc) begin
                        sh_prescale    <= cfg_prescale;
                        sh_parity_en   <= cfg_parity_en;
                        sh_parity_type <= cfg_parity_type;
                    end else if (line_idle) begin
                        prescale    <= sh_prescale;
                        parity_en   <= sh_parity_en;
                        parity_type <= sh_parity_type;
                        state       <= CFG_IDLE;
                        cfg_pending <= 1'b0;
                    end
                end
                default: state <= CFG_IDLE;
            endcase
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AWIDTH] != rd_ptr[AWIDTH]) &&
                   (wr_ptr[AWIDTH-1:0] == rd_ptr[AWIDTH-1:0]);
    assign pop   = !empty && rd_ready;
    assign push  = rx_data_valid && (!full || pop);
    assign drop  = rx_data_valid && full && !pop;

    assign rd_valid   = !empty;
    assign rd_data    = mem[rd_ptr[AWIDTH-1:0]];
    assign fifo_level = wr_ptr - rd_ptr;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AWIDTH-1:0]] <= rx_p_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (drop)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

`ifdef UART_RX_CTRL_TIMEOUT_EN
    logic [TW-1:0] tmo_cnt;
    logic [TW-1:0] tmo_nxt;
    logic [TW-1:0] tmo_thr;

    assign tmo_thr = {idle_thr, 2'b00};

    always_comb begin
        tmo_nxt = tmo_cnt;
        if (empty || push || pop)
            tmo_nxt = '0;
        else if (tmo_cnt < tmo_thr)
            tmo_nxt = tmo_cnt + TW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt    <= '0;
            rx_timeout <= 1'b0;
        end else begin
            tmo_cnt    <= tmo_nxt;
            rx_timeout <= (tmo_nxt >= tmo_thr);
        end
    end
`else
    assign rx_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl.
// Covers idle-gated config, FIFO order, overflow, reset and timeout.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_data;
    logic [7:0] rx_p_data;
    logic       rx_data_valid;
    logic [5:0] prescale;
    logic       parity_en;
    logic       parity_type;
    logic       cfg_wr;
    logic [5:0] cfg_prescale;
    logic       cfg_parity_en;
    logic       cfg_parity_type;
    logic       cfg_pending;
    logic       line_idle;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [3:0] fifo_level;
    logic       overflow;
    logic       ovf_clr;
    logic       rx_timeout;

    int checks = 0;
    int errors = 0;

    uart_rx_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .s_data          (s_data),
        .rx_p_data       (rx_p_data),
        .rx_data_valid   (rx_data_valid),
        .prescale        (prescale),
        .parity_en       (parity_en),
        .parity_type     (parity_type),
        .cfg_wr          (cfg_wr),
        .cfg_prescale    (cfg_prescale),
        .cfg_parity_en   (cfg_parity_en),
        .cfg_parity_type (cfg_parity_type),
        .cfg_pending     (cfg_pending),
        .line_idle       (line_idle),
        .rd_data         (rd_data),
        .rd_valid        (rd_valid),
        .rd_ready        (rd_ready),
        .fifo_level      (fifo_level),
        .overflow        (overflow),
        .ovf_clr         (ovf_clr),
        .rx_timeout      (rx_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d);
        rx_p_data     = d;
        rx_data_valid = 1'b1;
        tick();
        rx_data_valid = 1'b0;
    endtask

    task automatic cfg_write(input logic [5:0] ps, input logic pe, input logic pt);
        cfg_prescale    = ps;
        cfg_parity_en   = pe;
        cfg_parity_type = pt;
        cfg_wr          = 1'b1;
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #3;
        rst = 1'b1;
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (prescale !== 6'd8 || parity_en !== 1'b1 || parity_type !== 1'b0) begin
            errors++;
            $display("FAIL %s_cfg: got ps=%0d pe=%b pt=%b expected ps=8 pe=1 pt=0",
                     tag, prescale, parity_en, parity_type);
        end
        checks++;
        if (cfg_pending !== 1'b0 || line_idle !== 1'b0) begin
            errors++;
            $display("FAIL %s_flags: got pend=%b idle=%b expected 0 0",
                     tag, cfg_pending, line_idle);
        end
        checks++;
        if (rd_valid !== 1'b0 || fifo_level !== 4'd0) begin
            errors++;
            $display("FAIL %s_fifo: got valid=%b level=%0d expected 0 0",
                     tag, rd_valid, fifo_level);
        end
        checks++;
        if (overflow !== 1'b0 || rx_timeout !== 1'b0) begin
            errors++;
            $display("FAIL %s_ovf_tmo: got ovf=%b tmo=%b expected 0 0",
                     tag, overflow, rx_timeout);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        check_reset_outputs("reset");
        rst = 1'b1;
        tick();
    endtask

    task automatic test_cfg_idle();
        s_data = 1'b1;
        repeat (100) tick();
        checks++;
        if (line_idle !== 1'b1) begin
            errors++;
            $display("FAIL idle_detect: got %b expected 1", line_idle);
        end
        cfg_write(6'd16, 1'b0, 1'b0);
        checks++;
        if (cfg_pending !== 1'b1 || prescale !== 6'd8) begin
            errors++;
            $display("FAIL idle_cfg_pend: got pend=%b ps=%0d expected 1 8",
                     cfg_pending, prescale);
        end
        tick();
        checks++;
        if (cfg_pending !== 1'b0 || prescale !== 6'd16 || parity_en !== 1'b0) begin
            errors++;
            $display("FAIL idle_cfg_apply: got pend=%b ps=%0d pe=%b expected 0 16 0",
                     cfg_pending, prescale, parity_en);
        end
        repeat (100) tick();
        cfg_write(6'd4, 1'b0, 1'b0);
        cfg_write(6'd5, 1'b1, 1'b1);
        checks++;
        if (cfg_pending !== 1'b1 || prescale !== 6'd16) begin
            errors++;
            $display("FAIL cfg_suppress: got pend=%b ps=%0d expected 1 16",
                     cfg_pending, prescale);
        end
        tick();
        checks++;
        if (prescale !== 6'd5 || parity_en !== 1'b1 || parity_type !== 1'b1) begin
            errors++;
            $display("FAIL cfg_newest: got ps=%0d pe=%b pt=%b expected 5 1 1",
                     prescale, parity_en, parity_type);
        end
        cfg_write(6'd0, 1'b0, 1'b0);
        checks++;
        if (cfg_pending !== 1'b0) begin
            errors++;
            $display("FAIL cfg_zero_pend: got %b expected 0", cfg_pending);
        end
        tick();
        checks++;
        if (prescale !== 6'd5 || parity_en !== 1'b1) begin
            errors++;
            $display("FAIL cfg_zero_keep: got ps=%0d pe=%b expected 5 1",
                     prescale, parity_en);
        end
    endtask

    task automatic test_cfg_midframe();
        logic [7:0] frame;
        frame  = 8'h55;
        s_data = 1'b1;
        repeat (100) tick();
        s_data = 1'b0;
        repeat (4) tick();
        cfg_write(6'd16, 1'b0, 1'b0);
        repeat (3) tick();
        checks++;
        if (cfg_pending !== 1'b1 || line_idle !== 1'b0) begin
            errors++;
            $display("FAIL mid_pend: got pend=%b idle=%b expected 1 0",
                     cfg_pending, line_idle);
        end
        cfg_prescale    = 6'd20;
        cfg_parity_en   = 1'b1;
        cfg_parity_type = 1'b1;
        for (int b = 0; b < 8; b++) begin
            s_data = frame[b];
            for (int j = 0; j < 8; j++) begin
                cfg_wr = (b == 3 && j == 0);
                tick();
            end
        end
        cfg_wr = 1'b0;
        s_data = 1'b1;
        repeat (87) tick();
        checks++;
        if (line_idle !== 1'b0 || prescale !== 6'd8 || cfg_pending !== 1'b1) begin
            errors++;
            $display("FAIL mid_hold87: got idle=%b ps=%0d pend=%b expected 0 8 1",
                     line_idle, prescale, cfg_pending);
        end
        tick();
        checks++;
        if (line_idle !== 1'b1 || prescale !== 6'd8) begin
            errors++;
            $display("FAIL mid_idle88: got idle=%b ps=%0d expected 1 8",
                     line_idle, prescale);
        end
        tick();
        checks++;
        if (prescale !== 6'd20 || parity_type !== 1'b1 || cfg_pending !== 1'b0) begin
            errors++;
            $display("FAIL mid_apply: got ps=%0d pt=%b pend=%b expected 20 1 0",
                     prescale, parity_type, cfg_pending);
        end
    endtask

    task automatic test_fifo_order();
        logic [7:0] exp [3];
        exp = '{8'hA5, 8'h3C, 8'hFF};
        for (int i = 0; i < 3; i++) push_byte(exp[i]);
        checks++;
        if (fifo_level !== 4'd3 || rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL order_level: got lvl=%0d valid=%b expected 3 1",
                     fifo_level, rd_valid);
        end
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rd_data !== exp[i] || fifo_level !== 4'(3 - i)) begin
                errors++;
                $display("FAIL order_pop%0d: got data=%h lvl=%0d expected %h %0d",
                         i, rd_data, fifo_level, exp[i], 3 - i);
            end
            tick();
        end
        rd_ready = 1'b0;
        checks++;
        if (rd_valid !== 1'b0 || fifo_level !== 4'd0) begin
            errors++;
            $display("FAIL order_empty: got valid=%b lvl=%0d expected 0 0",
                     rd_valid, fifo_level);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) push_byte(8'(8'h10 + i));
        checks++;
        if (fifo_level !== 4'd8 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_full: got lvl=%0d ovf=%b expected 8 0",
                     fifo_level, overflow);
        end
        push_byte(8'h18);
        checks++;
        if (fifo_level !== 4'd8 || overflow !== 1'b1 || rd_data !== 8'h10) begin
            errors++;
            $display("FAIL ovf_set: got lvl=%0d ovf=%b head=%h expected 8 1 10",
                     fifo_level, overflow, rd_data);
        end
        ovf_clr = 1'b1;
        push_byte(8'h19);
        ovf_clr = 1'b0;
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set_wins: got %b expected 1", overflow);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0 || rd_data !== 8'h10) begin
            errors++;
            $display("FAIL ovf_clr: got ovf=%b head=%h expected 0 10",
                     overflow, rd_data);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp [8];
        exp = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h99};
        rx_p_data     = 8'h99;
        rx_data_valid = 1'b1;
        rd_ready      = 1'b1;
        tick();
        rx_data_valid = 1'b0;
        rd_ready      = 1'b0;
        checks++;
        if (fifo_level !== 4'd8 || overflow !== 1'b0 || rd_data !== 8'h11) begin
            errors++;
            $display("FAIL full_pp: got lvl=%0d ovf=%b head=%h expected 8 0 11",
                     fifo_level, overflow, rd_data);
        end
        rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rd_data !== exp[i]) begin
                errors++;
                $display("FAIL full_drain%0d: got %h expected %h", i, rd_data, exp[i]);
            end
            tick();
        end
        rd_ready = 1'b0;
        checks++;
        if (fifo_level !== 4'd0) begin
            errors++;
            $display("FAIL full_drained: got %0d expected 0", fifo_level);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) push_byte(8'(i + 1));
        s_data = 1'b0;
        tick();
        cfg_write(6'd12, 1'b0, 1'b1);
        checks++;
        if (fifo_level !== 4'd5 || cfg_pending !== 1'b1) begin
            errors++;
            $display("FAIL rmid_pre: got lvl=%0d pend=%b expected 5 1",
                     fifo_level, cfg_pending);
        end
        rst = 1'b0;
        #2;
        check_reset_outputs("rmid");
        #2;
        rst    = 1'b1;
        s_data = 1'b1;
        tick();
    endtask

    task automatic test_timeout();
        push_byte(8'h42);
`ifdef UART_RX_CTRL_TIMEOUT_EN
        repeat (351) tick();
        checks++;
        if (rx_timeout !== 1'b0) begin
            errors++;
            $display("FAIL tmo_early: got %b expected 0", rx_timeout);
        end
        tick();
        checks++;
        if (rx_timeout !== 1'b1) begin
            errors++;
            $display("FAIL tmo_set: got %b expected 1", rx_timeout);
        end
`else
        repeat (400) tick();
        checks++;
        if (rx_timeout !== 1'b0) begin
            errors++;
            $display("FAIL tmo_tied: got %b expected 0", rx_timeout);
        end
`endif
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        checks++;
        if (rx_timeout !== 1'b0 || fifo_level !== 4'd0) begin
            errors++;
            $display("FAIL tmo_clear: got tmo=%b lvl=%0d expected 0 0",
                     rx_timeout, fifo_level);
        end
    endtask

    initial begin
        rst             = 1'b0;
        s_data          = 1'b1;
        rx_p_data       = '0;
        rx_data_valid   = 1'b0;
        cfg_wr          = 1'b0;
        cfg_prescale    = '0;
        cfg_parity_en   = 1'b0;
        cfg_parity_type = 1'b0;
        rd_ready        = 1'b0;
        ovf_clr         = 1'b0;
        test_reset();
        test_cfg_idle();
        do_reset();
        test_cfg_midframe();
        test_fifo_order();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
